// File: rtl/clb_pkg.sv
// clb_pkg: shared types, SR mode codes and config field offsets for the CLB tile
package clb_pkg;
  typedef enum logic [1:0] {UNCFG, LOAD, ACTIVE} cfg_state_t;
  localparam logic [1:0] SRM_NONE = 2'b00;
  localparam logic [1:0] SRM_SET = 2'b01;
  localparam logic [1:0] SRM_CLR = 2'b10;
  function automatic int truth_lsb(input int k);
    return 0 * k;
  endfunction
  function automatic int fb_bit(input int k);
    return 1 << k;
  endfunction
  function automatic int out_bit(input int k);
    return (1 << k) + 1;
  endfunction
  function automatic int srm_lsb(input int k);
    return (1 << k) + 2;
  endfunction
  function automatic int cell_w(input int k);
    return (1 << k) + 4;
  endfunction
endpackage

// File: rtl/clb_lut_cell.sv
// clb_lut_cell: one LUT with storage flop, own-Q feedback and comb/registered output select
module clb_lut_cell
  import clb_pkg::*;
#(
  parameter int LUT_K = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic [2**LUT_K+3:0]  cfg,
  input  logic [LUT_K-1:0]     lut_in,
  input  logic                 ce,
  input  logic                 sr,
  output logic                 y
);
  logic [2**LUT_K-1:0] truth;
  logic [LUT_K-1:0] idx;
  logic [1:0] srm;
  logic fb_sel, out_sel, q, f;
  always_comb begin
    truth = cfg[truth_lsb(LUT_K) +: 2**LUT_K];
    fb_sel = cfg[fb_bit(LUT_K)];
    out_sel = cfg[out_bit(LUT_K)];
    srm = cfg[srm_lsb(LUT_K) +: 2];
    idx = lut_in;
    idx[LUT_K-1] = fb_sel ? q : lut_in[LUT_K-1];
    f = truth[idx];
    y = active & (out_sel ? q : f);
  end
  // SR only acts when the mode matches; code 11 behaves like no SR
  always_ff @(posedge clk)
    if (rst) q <= 1'b0;
    else if (active)
      q <= (srm == SRM_SET && sr) ? 1'b1 :
           (srm == SRM_CLR && sr) ? 1'b0 :
           ce ? f : q;
endmodule

// File: rtl/clb_array_cfg.sv
// clb_array_cfg: CLB tile with bit-serial config chain; CLB_CFG_CHAIN_EN enables registered CFG_DOUT
module clb_array_cfg
  import clb_pkg::*;
#(
  parameter int NUM_LUTS = 2,
  parameter int LUT_K = 4
) (
  input  logic                      K,
  input  logic                      RST,
  input  logic [NUM_LUTS*LUT_K-1:0] IN,
  input  logic [NUM_LUTS-1:0]       CE,
  input  logic [NUM_LUTS-1:0]       SR,
  input  logic                      CFG_EN,
  input  logic                      CFG_DIN,
  output logic                      CFG_DOUT,
  output logic                      CFG_DONE,
  output logic [NUM_LUTS-1:0]       OUT
);
  localparam int CELL_W = cell_w(LUT_K);
  localparam int CFG_BITS = NUM_LUTS * CELL_W;
  localparam int CW = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(CFG_BITS - 1);
  cfg_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CFG_BITS-1:0] cfg;
  always_ff @(posedge K)
    if (RST) begin
      state <= UNCFG;
      cnt <= '0;
      cfg <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (CFG_EN) cfg <= {CFG_DIN, cfg[CFG_BITS-1:1]};
    end
  // any shift outside LOAD (first load or reconfiguration) restarts the count at 1
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (CFG_EN) begin
      state_n = (state == LOAD && cnt == LAST) ? ACTIVE : LOAD;
      cnt_n = (state != LOAD) ? CW'(1) : (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end
  assign CFG_DONE = (state == ACTIVE);
`ifdef CLB_CFG_CHAIN_EN
  logic dout;
  always_ff @(posedge K)
    if (RST) dout <= 1'b0;
    else if (CFG_EN) dout <= cfg[0];
  assign CFG_DOUT = dout;
`else
  assign CFG_DOUT = 1'b0;
`endif
  for (genvar n = 0; n < NUM_LUTS; n++) begin : g_cell
    clb_lut_cell #(.LUT_K(LUT_K)) u_cell (
      .clk(K),
      .rst(RST),
      .active(CFG_DONE),
      .cfg(cfg[n*CELL_W +: CELL_W]),
      .lut_in(IN[n*LUT_K +: LUT_K]),
      .ce(CE[n]),
      .sr(SR[n]),
      .y(OUT[n])
    );
  end
endmodule

// File: tb/tb_clb_array_cfg.sv
// tb_clb_array_cfg: directed self-checking bench for the default 2x LUT4 tile
module tb_clb_array_cfg;
  logic K = 1'b0;
  logic RST = 1'b1;
  logic [7:0] IN = '0;
  logic [1:0] CE = '0, SR = '0;
  logic CFG_EN = 1'b0, CFG_DIN = 1'b0;
  logic CFG_DOUT, CFG_DONE;
  logic [1:0] OUT;
  int total = 0, bad = 0;

  always #5 K = ~K;

  clb_array_cfg dut (
    .K(K), .RST(RST), .IN(IN), .CE(CE), .SR(SR),
    .CFG_EN(CFG_EN), .CFG_DIN(CFG_DIN),
    .CFG_DOUT(CFG_DOUT), .CFG_DONE(CFG_DONE), .OUT(OUT)
  );

  function automatic logic [19:0] fld(input logic [15:0] t, input logic fb, input logic os, input logic [1:0] srm);
    return {srm, os, fb, t};
  endfunction

  task automatic shift_bits(input logic [39:0] v, input int lo, input int hi);
    CE = '0;
    SR = '0;
    for (int i = lo; i <= hi; i++) begin
      CFG_EN = 1'b1;
      CFG_DIN = v[i];
      @(negedge K);
    end
    CFG_EN = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] pats [4];
    pats = '{8'hFF, 8'h77, 8'h0F, 8'hA5};
    RST = 1'b1; CFG_EN = 1'b1; CFG_DIN = 1'b1; SR = 2'b11;
    @(negedge K);
    RST = 1'b0; CFG_EN = 1'b0; SR = '0;
    total++; if (OUT !== 2'b00) begin bad++; $display("FAIL reset_out got=%b exp=00", OUT); end
    total++; if (CFG_DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", CFG_DONE); end
    total++; if (CFG_DOUT !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b exp=0", CFG_DOUT); end
    for (int i = 0; i < 4; i++) begin
      IN = pats[i]; CE = 2'b11;
      #1;
      total++; if (OUT !== 2'b00) begin bad++; $display("FAIL idle_out[%0d] got=%b exp=00", i, OUT); end
      @(negedge K);
      total++; if (CFG_DONE !== 1'b0) begin bad++; $display("FAIL idle_done[%0d] got=%b exp=0", i, CFG_DONE); end
    end
    CE = '0;
  endtask

  task automatic test_comb;
    logic [39:0] v;
    logic [3:0] nib [5];
    logic exp_o [5];
    nib = '{4'b0111, 4'b0000, 4'b0011, 4'b1000, 4'b1111};
    exp_o = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v = {fld(16'h0000, 0, 0, 2'b00), fld(16'h6996, 0, 0, 2'b00)};
    shift_bits(v, 0, 38);
    total++; if (CFG_DONE !== 1'b0) begin bad++; $display("FAIL comb_done39 got=%b exp=0", CFG_DONE); end
    total++; if (OUT !== 2'b00) begin bad++; $display("FAIL comb_gated got=%b exp=00", OUT); end
    shift_bits(v, 39, 39);
    total++; if (CFG_DONE !== 1'b1) begin bad++; $display("FAIL comb_done40 got=%b exp=1", CFG_DONE); end
    for (int i = 0; i < 5; i++) begin
      IN = {4'hC, nib[i]};
      #1;
      total++; if (OUT !== {1'b0, exp_o[i]}) begin bad++; $display("FAIL comb_parity[%0d] got=%b exp=%b", i, OUT, {1'b0, exp_o[i]}); end
    end
    @(negedge K);
  endtask

  task automatic test_registered;
    logic [39:0] v;
    v = {fld(16'h8000, 0, 1, 2'b00), fld(16'h0000, 0, 0, 2'b00)};
    shift_bits(v, 0, 39);
    IN = 8'hF0; CE = 2'b10;
    #1;
    total++; if (OUT !== 2'b00) begin bad++; $display("FAIL reg_before got=%b exp=00", OUT); end
    @(negedge K);
    total++; if (OUT !== 2'b10) begin bad++; $display("FAIL reg_after got=%b exp=10", OUT); end
    IN = 8'hE0;
    #1;
    total++; if (OUT !== 2'b10) begin bad++; $display("FAIL reg_hold got=%b exp=10", OUT); end
    @(negedge K);
    total++; if (OUT !== 2'b00) begin bad++; $display("FAIL reg_fall got=%b exp=00", OUT); end
    CE = '0;
  endtask

  task automatic test_sr;
    logic [39:0] v;
    v = {fld(16'h8000, 0, 1, 2'b10), fld(16'h0000, 0, 0, 2'b00)};
    shift_bits(v, 0, 39);
    IN = 8'hF0; CE = 2'b10;
    @(negedge K);
    total++; if (OUT !== 2'b10) begin bad++; $display("FAIL sr_preset got=%b exp=10", OUT); end
    SR = 2'b10;
    @(negedge K);
    total++; if (OUT !== 2'b00) begin bad++; $display("FAIL sr_clear got=%b exp=00", OUT); end
    v = {fld(16'h8000, 0, 1, 2'b00), fld(16'h0000, 0, 0, 2'b00)};
    shift_bits(v, 0, 39);
    IN = 8'hF0; CE = 2'b10; SR = 2'b10;
    @(negedge K);
    total++; if (OUT !== 2'b10) begin bad++; $display("FAIL sr_ignored got=%b exp=10", OUT); end
    CE = 2'b00;
    @(negedge K);
    total++; if (OUT !== 2'b10) begin bad++; $display("FAIL sr_ignored_hold got=%b exp=10", OUT); end
    v = {fld(16'h8000, 0, 1, 2'b01), fld(16'h0000, 0, 0, 2'b00)};
    shift_bits(v, 0, 39);
    IN = 8'h00; CE = 2'b10; SR = 2'b00;
    @(negedge K);
    total++; if (OUT !== 2'b00) begin bad++; $display("FAIL sr_ce_load got=%b exp=00", OUT); end
    SR = 2'b10;
    @(negedge K);
    total++; if (OUT !== 2'b10) begin bad++; $display("FAIL sr_set got=%b exp=10", OUT); end
    SR = '0; CE = '0;
  endtask

  task automatic test_feedback;
    logic [39:0] v;
    v = {fld(16'h0000, 0, 0, 2'b00), fld(16'h00FF, 1, 1, 2'b00)};
    shift_bits(v, 0, 39);
    IN = 8'h0F;
    #1;
    total++; if (OUT !== 2'b00) begin bad++; $display("FAIL fb_start got=%b exp=00", OUT); end
    CE = 2'b01;
    for (int i = 0; i < 6; i++) begin
      @(negedge K);
      total++; if (OUT !== {1'b0, (i % 2 == 0)}) begin bad++; $display("FAIL fb_toggle[%0d] got=%b exp=%b", i, OUT, {1'b0, (i % 2 == 0)}); end
    end
    CE = '0;
  endtask

  task automatic test_pause;
    logic [39:0] v;
    v = {fld(16'hFFFF, 0, 0, 2'b00), fld(16'h6996, 0, 0, 2'b00)};
    IN = 8'h07;
    shift_bits(v, 0, 19);
    total++; if (OUT !== 2'b00) begin bad++; $display("FAIL pause_gated got=%b exp=00", OUT); end
    for (int i = 0; i < 5; i++) begin
      @(negedge K);
      total++; if (CFG_DONE !== 1'b0) begin bad++; $display("FAIL pause_done[%0d] got=%b exp=0", i, CFG_DONE); end
    end
    shift_bits(v, 20, 38);
    total++; if (CFG_DONE !== 1'b0) begin bad++; $display("FAIL pause_done39 got=%b exp=0", CFG_DONE); end
    shift_bits(v, 39, 39);
    total++; if (CFG_DONE !== 1'b1) begin bad++; $display("FAIL pause_done40 got=%b exp=1", CFG_DONE); end
    total++; if (OUT !== 2'b11) begin bad++; $display("FAIL pause_out got=%b exp=11", OUT); end
  endtask

  task automatic test_reset_midload;
    logic [39:0] v;
    v = {fld(16'h0000, 0, 0, 2'b00), fld(16'hFFFF, 0, 0, 2'b00)};
    shift_bits(v, 0, 29);
    RST = 1'b1; CFG_EN = 1'b1;
    @(negedge K);
    RST = 1'b0; CFG_EN = 1'b0;
    total++; if (CFG_DONE !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b exp=0", CFG_DONE); end
    total++; if (OUT !== 2'b00) begin bad++; $display("FAIL mid_rst_out got=%b exp=00", OUT); end
    shift_bits(v, 0, 38);
    total++; if (CFG_DONE !== 1'b0) begin bad++; $display("FAIL mid_rst_done39 got=%b exp=0", CFG_DONE); end
    shift_bits(v, 39, 39);
    total++; if (CFG_DONE !== 1'b1) begin bad++; $display("FAIL mid_rst_done40 got=%b exp=1", CFG_DONE); end
    total++; if (OUT !== 2'b01) begin bad++; $display("FAIL mid_rst_out40 got=%b exp=01", OUT); end
  endtask

  task automatic test_chain;
    logic [39:0] v;
    logic exp_b;
    v = 40'hA5_3C_96_0F_E1;
    shift_bits(v, 0, 39);
    for (int i = 0; i < 8; i++) begin
      CFG_EN = 1'b1; CFG_DIN = 1'b0;
      @(negedge K);
`ifdef CLB_CFG_CHAIN_EN
      exp_b = v[i];
`else
      exp_b = 1'b0;
`endif
      total++; if (CFG_DOUT !== exp_b) begin bad++; $display("FAIL chain_dout[%0d] got=%b exp=%b", i, CFG_DOUT, exp_b); end
    end
    CFG_EN = 1'b0;
    total++; if (CFG_DONE !== 1'b0) begin bad++; $display("FAIL chain_reload_done got=%b exp=0", CFG_DONE); end
  endtask

  initial begin
    test_reset;
    test_comb;
    test_registered;
    test_sr;
    test_feedback;
    test_pause;
    test_reset_midload;
    test_chain;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
